// File: rtl/serial_xor_sequencer_if.sv
// Handshake and operand/result bundle for the serial XOR sequencer.
interface serial_xor_sequencer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             parity;
   logic             busy;

   // Producer/consumer side: drives operands and accepts results.
   modport master (
      output in_valid, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, parity, busy
   );

   // Sequencer side.
   modport slave (
      input  in_valid, op_a, op_b, out_ready,
      output in_ready, out_valid, result, parity, busy
   );
endinterface

// File: rtl/serial_xor_sequencer.sv
// Bit-serial XOR of two operands with running parity, one bit per cycle.
// Operands are consumed LSB first; each xor bit enters the result at the MSB,
// so after WIDTH shifts the result lines up with the operand bit positions.

// Single two-input XOR cell; the sequencer computes only through instances.
module xor_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i ^ b_i;
endmodule

module serial_xor_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_xor_sequencer_if.slave   bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_SHIFT = 2'b01;
   localparam logic [1:0] S_DONE  = 2'b10;

   logic [1:0]       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] a_sh_q,      a_sh_d;
   logic [WIDTH-1:0] b_sh_q,      b_sh_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             parity_q,    parity_d;
   logic             acc_q,       acc_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q,      busy_d;

   logic bit_x;
   logic par_x;

   // Current operand bit pair.
   xor_gate u_bit_xor (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .y_o (bit_x)
   );

   // Running parity over the xor bits produced so far.
   xor_gate u_par_xor (
      .a_i (acc_q),
      .b_i (bit_x),
      .y_o (par_x)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      parity_d = parity_q;
      acc_d    = acc_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_SHIFT;
               a_sh_d  = bus.op_a;
               b_sh_d  = bus.op_b;
               cnt_d   = '0;
               acc_d   = 1'b0;
            end
         end
         S_SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            result_d = {bit_x, result_q[WIDTH-1:1]};
            acc_d    = par_x;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = S_DONE;
               parity_d = par_x;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State, datapath and output registers; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         result_q    <= '0;
         parity_q    <= 1'b0;
         acc_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         result_q    <= result_d;
         parity_q    <= parity_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.parity    = parity_q;
   assign bus.busy      = busy_q;
endmodule
